// File: rtl/conv_engine_seq.sv
// Sequential KxKxCH convolution engine: one shared MAC window, issue -> product -> sum/bias/ReLU
// pipeline streaming one result per cycle under valid/ready backpressure.
module conv_engine_seq #(
    parameter int unsigned IN_H    = 8,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned CH      = 3,
    parameter int unsigned K       = 3,
    parameter int unsigned NFILT   = 4,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned DATA_W  = 17,
    parameter int unsigned RELU_EN = 1,
    localparam int unsigned OH     = (IN_H - K) / STRIDE + 1,
    localparam int unsigned OW     = (IN_W - K) / STRIDE + 1,
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(K * K * CH),
    localparam int unsigned OUT_W  = ACC_W + 1,
    localparam int unsigned NOUT   = NFILT * OH * OW,
    localparam int unsigned ADDR_W = $clog2(NOUT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    input  logic [IN_H*IN_W*CH*DATA_W-1:0]    in_tensor,
    input  logic [NFILT*K*K*CH*DATA_W-1:0]    filters,
    input  logic [NFILT*ACC_W-1:0]            bias,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_W-1:0]                  out_data,
    output logic [ADDR_W-1:0]                 out_addr,
    output logic                              out_last
);

    localparam int unsigned NPROD = K * K * CH;
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned R_W   = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned C_W   = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned F_W   = (NFILT > 1) ? $clog2(NFILT) : 1;
    localparam int unsigned HI_W  = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int unsigned WI_W  = (IN_W > 1) ? $clog2(IN_W) : 1;

    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
        $error("conv_engine_seq: STRIDE must be 1 or 2");
    end
    if (K > IN_H || K > IN_W) begin : g_bad_kernel
        $error("conv_engine_seq: K must not exceed IN_H or IN_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic [C_W-1:0]    cnt_c;
    logic [R_W-1:0]    cnt_r;
    logic [F_W-1:0]    cnt_f;
    logic [ADDR_W-1:0] cnt_addr;

    logic              iss_valid, iss_last;
    logic [C_W-1:0]    iss_c;
    logic [R_W-1:0]    iss_r;
    logic [F_W-1:0]    iss_f;
    logic [ADDR_W-1:0] iss_addr;

    logic              s1_valid, s1_last;
    logic [F_W-1:0]    s1_f;
    logic [ADDR_W-1:0] s1_addr;
    logic signed [PW-1:0] s1_prod [NPROD];

    logic signed [DATA_W-1:0] px [IN_H][IN_W][CH];
    logic signed [DATA_W-1:0] wt [NFILT][K][K][CH];
    logic signed [ACC_W-1:0]  bs [NFILT];
    logic [HI_W-1:0]          win_row [K];
    logic [WI_W-1:0]          win_col [K];
    logic signed [PW-1:0]     prod_c [NPROD];
    logic signed [ACC_W-1:0]  psum [NPROD+1];
    logic signed [OUT_W-1:0]  sum_b_c, res_c;

    logic adv, issue, last_pos;

    // A stage moves only when the output register is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign issue    = (state == S_RUN) && adv;
    assign last_pos = (cnt_c == C_W'(OW - 1)) && (cnt_r == R_W'(OH - 1))
                   && (cnt_f == F_W'(NFILT - 1));

    // Operand views of the flat buses.
    for (genvar r = 0; r < IN_H; r++) begin : g_px_r
        for (genvar c = 0; c < IN_W; c++) begin : g_px_c
            for (genvar ch = 0; ch < CH; ch++) begin : g_px_ch
                assign px[r][c][ch] = in_tensor[((r*IN_W+c)*CH+ch)*DATA_W +: DATA_W];
            end
        end
    end
    for (genvar f = 0; f < NFILT; f++) begin : g_wt_f
        assign bs[f] = bias[f*ACC_W +: ACC_W];
        for (genvar i = 0; i < K; i++) begin : g_wt_i
            for (genvar j = 0; j < K; j++) begin : g_wt_j
                for (genvar ch = 0; ch < CH; ch++) begin : g_wt_ch
                    assign wt[f][i][j][ch] = filters[(((f*K+i)*K+j)*CH+ch)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Window taps and products for the issued position.
    for (genvar i = 0; i < K; i++) begin : g_win
        assign win_row[i] = HI_W'(iss_r) * HI_W'(STRIDE) + HI_W'(i);
        assign win_col[i] = WI_W'(iss_c) * WI_W'(STRIDE) + WI_W'(i);
    end
    for (genvar i = 0; i < K; i++) begin : g_prod_i
        for (genvar j = 0; j < K; j++) begin : g_prod_j
            for (genvar ch = 0; ch < CH; ch++) begin : g_prod_ch
                localparam int unsigned N = (i*K+j)*CH+ch;
                assign prod_c[N] = PW'(px[win_row[i]][win_col[j]][ch]) * PW'(wt[iss_f][i][j][ch]);
            end
        end
    end

    // Sign-extended reduction of the registered products, then bias and optional ReLU.
    assign psum[0] = '0;
    for (genvar n = 0; n < NPROD; n++) begin : g_sum
        assign psum[n+1] = psum[n] + ACC_W'(s1_prod[n]);
    end
    assign sum_b_c = OUT_W'(psum[NPROD]) + OUT_W'(bs[s1_f]);
    assign res_c   = (RELU_EN != 0 && sum_b_c[OUT_W-1]) ? '0 : sum_b_c;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (issue && last_pos) state_nx = S_DRAIN;
            S_DRAIN: if (out_valid && out_ready && out_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN, S_DRAIN: busy = 1'b1;
            S_DONE:         done = 1'b1;
            default:        ;
        endcase
    end

    // Position counters: c fastest, then r, then f.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            cnt_c    <= '0;
            cnt_r    <= '0;
            cnt_f    <= '0;
            cnt_addr <= '0;
        end else if (issue) begin
            cnt_addr <= cnt_addr + ADDR_W'(1);
            if (cnt_c == C_W'(OW - 1)) begin
                cnt_c <= '0;
                if (cnt_r == R_W'(OH - 1)) begin
                    cnt_r <= '0;
                    cnt_f <= cnt_f + F_W'(1);
                end else begin
                    cnt_r <= cnt_r + R_W'(1);
                end
            end else begin
                cnt_c <= cnt_c + C_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_last  <= 1'b0;
            iss_c     <= '0;
            iss_r     <= '0;
            iss_f     <= '0;
            iss_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_f      <= '0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (adv) begin
            iss_valid <= issue;
            iss_last  <= issue && last_pos;
            iss_c     <= cnt_c;
            iss_r     <= cnt_r;
            iss_f     <= cnt_f;
            iss_addr  <= cnt_addr;
            s1_valid  <= iss_valid;
            s1_last   <= iss_last;
            s1_f      <= iss_f;
            s1_addr   <= iss_addr;
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                out_data <= res_c;
                out_addr <= s1_addr;
            end
        end
    end

    // Product data needs no reset; its valid bit travels in s1_valid.
    always_ff @(posedge clk) begin
        if (adv) s1_prod <= prod_c;
    end

endmodule

// File: tb/tb_conv_engine_seq.sv
// Self-checking bench for conv_engine_seq: two instances (stride 1 + ReLU, stride 2 without ReLU)
// checked against a loop-based convolution model.
module tb_conv_engine_seq;

    localparam int TW = 8*8*3*17;
    localparam int FW = 4*27*17;
    localparam int BW = 4*39;

    logic clk = 1'b0;
    logic rst, start, sel, out_ready;
    logic [TW-1:0] in_tensor;
    logic [FW-1:0] filters;
    logic [BW-1:0] bias;

    logic start1, start2;
    logic busy1, done1, ov1, ol1, busy2, done2, ov2, ol2;
    logic [39:0] od1, od2;
    logic [7:0]  oa1;
    logic [5:0]  oa2;

    logic busy_m, done_m, ov_m, ol_m;
    logic [39:0] od_m;
    logic [7:0]  oa_m;

    int tests = 0;
    int fails = 0;

    int     tens [8][8][3];
    int     filt [4][3][3][3];
    longint bias_v [4];
    longint exp_v [144];
    longint got_v [144];
    int     n_out;

    always #5 clk = ~clk;

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;
    assign ov_m   = sel ? ov2 : ov1;
    assign ol_m   = sel ? ol2 : ol1;
    assign od_m   = sel ? od2 : od1;
    assign oa_m   = sel ? {2'b00, oa2} : oa1;

    conv_engine_seq dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .in_tensor(in_tensor), .filters(filters), .bias(bias),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_addr(oa1), .out_last(ol1)
    );

    conv_engine_seq #(.STRIDE(2), .RELU_EN(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .in_tensor(in_tensor), .filters(filters), .bias(bias),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_addr(oa2), .out_last(ol2)
    );

    task automatic fill_const(input int tv, input int fv);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) for (int ch = 0; ch < 3; ch++)
            tens[r][c][ch] = tv;
        for (int f = 0; f < 4; f++) begin
            bias_v[f] = 0;
            for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int ch = 0; ch < 3; ch++)
                filt[f][i][j][ch] = fv;
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) for (int ch = 0; ch < 3; ch++)
            tens[r][c][ch] = int'($urandom_range(131071)) - 65536;
        for (int f = 0; f < 4; f++) begin
            bias_v[f] = longint'(int'($urandom));
            for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int ch = 0; ch < 3; ch++)
                filt[f][i][j][ch] = int'($urandom_range(131071)) - 65536;
        end
    endtask

    task automatic pack();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) for (int ch = 0; ch < 3; ch++)
            in_tensor[((r*8+c)*3+ch)*17 +: 17] = 17'(tens[r][c][ch]);
        for (int f = 0; f < 4; f++) begin
            bias[f*39 +: 39] = 39'(bias_v[f]);
            for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int ch = 0; ch < 3; ch++)
                filters[(((f*3+i)*3+j)*3+ch)*17 +: 17] = 17'(filt[f][i][j][ch]);
        end
    endtask

    // Direct convolution, results listed in filter / row / column order.
    task automatic build_model(input int stride, input int relu);
        int oh;
        longint acc;
        oh = (8 - 3) / stride + 1;
        n_out = 4 * oh * oh;
        for (int f = 0; f < 4; f++) for (int r = 0; r < oh; r++) for (int c = 0; c < oh; c++) begin
            acc = bias_v[f];
            for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) for (int ch = 0; ch < 3; ch++)
                acc += longint'(tens[r*stride+i][c*stride+j][ch]) * longint'(filt[f][i][j][ch]);
            if (relu != 0 && acc < 0) acc = 0;
            exp_v[f*oh*oh + r*oh + c] = acc;
        end
    endtask

    // One full tensor pass on the selected instance with the chosen out_ready pattern.
    task automatic run_pass(input bit s, input int mode, input int abort_after,
                            input bit check_lat, input int restart_at);
        int hs, first_v;
        bit prev_stall, last_seen, done_seen, abort_now;
        logic [39:0] h_d;
        logic [7:0]  h_a;
        logic        h_l;
        longint got;
        build_model(s ? 2 : 1, s ? 0 : 1);
        pack();
        sel = s;
        out_ready = 1'b1;
        hs = 0; first_v = -1; prev_stall = 0; last_seen = 0; done_seen = 0; abort_now = 0;
        h_d = '0; h_a = '0; h_l = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy_m !== 1'b1 || ov_m !== 1'b0) begin
            fails++; $display("FAIL busy_at_start: busy=%b valid=%b, required busy=1 valid=0", busy_m, ov_m);
        end
        for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
            if (prev_stall) begin
                tests++;
                if (ov_m !== 1'b1 || od_m !== h_d || oa_m !== h_a || ol_m !== h_l) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b data=%0d addr=%0d last=%b, required 1/%0d/%0d/%b",
                             ov_m, od_m, oa_m, ol_m, h_d, h_a, h_l);
                end
            end
            if (last_seen) begin
                tests++;
                if (done_m !== 1'b1 || busy_m !== 1'b0) begin
                    fails++; $display("FAIL done_pulse: done=%b busy=%b, required 1/0", done_m, busy_m);
                end
                done_seen = 1;
            end else begin
                if (ov_m === 1'b1 && first_v < 0) begin
                    first_v = cyc;
                    if (check_lat) begin
                        tests++;
                        if (cyc != 3) begin
                            fails++; $display("FAIL latency: first valid after %0d cycles, required 3", cyc);
                        end
                    end
                end
                case (mode)
                    1:       out_ready = (cyc % 2 == 0) && !(cyc >= 30 && cyc < 40);
                    2:       out_ready = 1'($urandom_range(1));
                    default: out_ready = 1'b1;
                endcase
                start = (cyc == restart_at);
                if (ov_m === 1'b1 && out_ready) begin
                    got = longint'($signed(od_m));
                    tests++;
                    if (oa_m !== 8'(hs)) begin
                        fails++; $display("FAIL addr_order: addr=%0d, required %0d", oa_m, hs);
                    end
                    if (hs < n_out) begin
                        got_v[hs] = got;
                        tests++;
                        if (got != exp_v[hs]) begin
                            fails++; $display("FAIL data[%0d]: got %0d, required %0d", hs, got, exp_v[hs]);
                        end
                    end
                    tests++;
                    if (ol_m !== 1'(hs == n_out - 1)) begin
                        fails++; $display("FAIL out_last[%0d]: got %b, required %b", hs, ol_m, hs == n_out - 1);
                    end
                    if (hs == n_out - 1) last_seen = 1;
                    hs++;
                    if (hs == abort_after) abort_now = 1;
                end
                prev_stall = (ov_m === 1'b1) && !out_ready;
                h_d = od_m; h_a = oa_m; h_l = ol_m;
                @(posedge clk); #1;
                start = 1'b0;
                if (abort_now) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    tests++;
                    if (ov_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0) begin
                        fails++; $display("FAIL abort_reset: valid=%b busy=%b done=%b, required 0/0/0",
                                          ov_m, busy_m, done_m);
                    end
                    rst = 1'b0;
                    out_ready = 1'b1;
                    return;
                end
            end
        end
        tests++;
        if (!done_seen || hs != n_out) begin
            fails++; $display("FAIL pass_complete: %0d handshakes, done=%b, required %0d and done", hs, done_seen, n_out);
        end
        @(posedge clk); #1;
        tests++;
        if (done_m !== 1'b0 || busy_m !== 1'b0) begin
            fails++; $display("FAIL post_done: done=%b busy=%b, required 0/0", done_m, busy_m);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            tests++;
            if (busy_m !== 1'b0 || done_m !== 1'b0 || ov_m !== 1'b0 || ol_m !== 1'b0
                || od_m !== 40'd0 || oa_m !== 8'd0) begin
                fails++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b valid=%b last=%b data=%0d addr=%0d, required all 0",
                         s, busy_m, done_m, ov_m, ol_m, od_m, oa_m);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        fill_const(1, 1);
        run_pass(1'b0, 0, 0, 1'b1, -1);
        tests++;
        if (got_v[0] != 27 || got_v[143] != 27) begin
            fails++; $display("FAIL ones_value: addr0=%0d addr143=%0d, required 27", got_v[0], got_v[143]);
        end
    endtask

    task automatic test_bias_relu();
        fill_const(1, 1);
        bias_v[1] = -30;
        run_pass(1'b0, 0, 0, 1'b0, -1);
        tests++;
        if (got_v[36] != 0 || got_v[71] != 0 || got_v[35] != 27 || got_v[72] != 27) begin
            fails++; $display("FAIL relu_bias: a35=%0d a36=%0d a71=%0d a72=%0d, required 27/0/0/27",
                              got_v[35], got_v[36], got_v[71], got_v[72]);
        end
        run_pass(1'b1, 0, 0, 1'b1, -1);
        tests++;
        if (got_v[9] != -3 || got_v[17] != -3 || got_v[8] != 27) begin
            fails++; $display("FAIL norelu_bias: a8=%0d a9=%0d a17=%0d, required 27/-3/-3",
                              got_v[8], got_v[9], got_v[17]);
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        run_pass(1'b0, 1, 0, 1'b0, -1);
        fill_random();
        run_pass(1'b1, 1, 0, 1'b0, -1);
    endtask

    task automatic test_random_ready();
        fill_random();
        run_pass(1'b0, 2, 0, 1'b0, -1);
    endtask

    task automatic test_stride2();
        fill_const(0, 0);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) for (int ch = 0; ch < 3; ch++)
            tens[r][c][ch] = r * 8 + c;
        filt[0][0][0][0] = 1;
        run_pass(1'b1, 0, 0, 1'b1, -1);
        tests++;
        if (got_v[4] != 18 || got_v[8] != 36) begin
            fails++; $display("FAIL stride2_taps: a4=%0d a8=%0d, required 18/36", got_v[4], got_v[8]);
        end
    endtask

    task automatic test_abort();
        fill_random();
        run_pass(1'b0, 0, 50, 1'b0, -1);
        run_pass(1'b0, 0, 0, 1'b1, -1);
    endtask

    task automatic test_extreme();
        fill_const(-65536, -65536);
        run_pass(1'b1, 0, 0, 1'b0, 20);
        tests++;
        if (got_v[0] != 64'sd115964116992 || got_v[35] != 64'sd115964116992) begin
            fails++; $display("FAIL extreme: a0=%0d a35=%0d, required 115964116992", got_v[0], got_v[35]);
        end
        run_pass(1'b0, 2, 0, 1'b0, 40);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; out_ready = 1'b1;
        in_tensor = '0; filters = '0; bias = '0;
        test_reset();
        test_all_ones();
        test_bias_relu();
        test_backpressure();
        test_random_ready();
        test_stride2();
        test_abort();
        test_extreme();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
